// File: rtl/breakout_pkg.sv
`default_nettype none
// ============================================================================
// Module      : breakout_pkg
// Description : Shared types and constants for the breakout rendering blocks:
//               draw FSM state encoding, default colours, coordinate width.
// Revision    : 1.0 - initial release
// ============================================================================
package breakout_pkg;

  // Width of every screen coordinate carried between stages
  localparam int c_coord_w = 10;

  // Default palette entries (3-bit RGB)
  localparam logic [2:0] c_bg_colour   = 3'b000;
  localparam logic [2:0] c_ball_colour = 3'b111;

  // Draw sequencer states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ERASE = 2'd1,
    S_DRAW  = 2'd2,
    S_DONE  = 2'd3
  } draw_state_t;

  // True when a coordinate sum (one bit wider than a coordinate, so it never
  // wraps) lies inside the visible range [0, limit)
  function automatic logic on_screen(input logic [c_coord_w:0] sum,
                                     input logic [c_coord_w:0] limit);
    return (sum < limit);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_scan.sv
`default_nettype none
// ============================================================================
// Module      : sprite_scan
// Description : Row-major offset generator for an N x N sprite. A start pulse
//               rewinds to (0,0); each advance steps one pixel. last flags the
//               final offset (N-1, N-1). size_m1 = N-1, N in 1..16.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_scan (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       advance,
  input  logic [3:0] size_m1,
  output logic [3:0] dx,
  output logic [3:0] dy,
  output logic       last
);

  // Step column then row; start takes priority over advance
  always_ff @(posedge clk) begin
    if (reset || start) begin
      dx <= 4'd0;
      dy <= 4'd0;
    end else if (advance) begin
      if (dx == size_m1) begin
        dx <= 4'd0;
        dy <= dy + 4'd1;
      end else begin
        dx <= dx + 4'd1;
      end
    end
  end

  assign last = (dx == size_m1) && (dy == size_m1);

endmodule
`default_nettype wire

// File: rtl/ball_draw_fsm.sv
`default_nettype none
// ============================================================================
// Module      : ball_draw_fsm
// Description : Renders each new ball position into the framebuffer: erases
//               the square at the previous position in BG_COLOUR, then draws
//               the square at the new position in BALL_COLOUR, one pixel
//               write per cycle. Off-screen pixels are suppressed without
//               changing latency.
//               Optional macro BALL_SKIP_STILL_EN: an unchanged position
//               skips erase/draw and completes straight away.
// Revision    : 1.0 - initial release
// ============================================================================
module ball_draw_fsm
  import breakout_pkg::*;
#(
  parameter int         BALL_SIZE   = 4,
  parameter int         SCREEN_W    = 160,
  parameter int         SCREEN_H    = 120,
  parameter logic [2:0] BG_COLOUR   = c_bg_colour,
  parameter logic [2:0] BALL_COLOUR = c_ball_colour
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [c_coord_w-1:0] X,
  input  logic [c_coord_w-1:0] Y,
  input  logic                 pos_valid,
  output logic                 ready,
  output logic [c_coord_w-1:0] plot_x,
  output logic [c_coord_w-1:0] plot_y,
  output logic [2:0]           colour,
  output logic                 plot,
  output logic                 done
);

  localparam logic [3:0]         c_size_m1  = 4'(BALL_SIZE - 1);
  localparam logic [c_coord_w:0] c_screen_w = (c_coord_w + 1)'(SCREEN_W);
  localparam logic [c_coord_w:0] c_screen_h = (c_coord_w + 1)'(SCREEN_H);

  draw_state_t          r_state;
  logic [c_coord_w-1:0] r_new_x, r_new_y;
  logic [c_coord_w-1:0] r_old_x, r_old_y;
  logic                 r_have_old;

  logic                 w_accept;
  logic                 w_scan_start;
  logic                 w_scan_adv;
  logic [3:0]           w_dx, w_dy;
  logic                 w_last;
  logic [c_coord_w-1:0] w_base_x, w_base_y;
  logic [c_coord_w:0]   w_sum_x, w_sum_y;
  logic                 w_visible;

  // Only IDLE accepts; a busy-time pos_valid is simply dropped
  assign w_accept = pos_valid && (r_state == S_IDLE);

  // Rewind the scan on accept and again when erase hands over to draw
  assign w_scan_start = w_accept || ((r_state == S_ERASE) && w_last);
  assign w_scan_adv   = (r_state == S_ERASE) || (r_state == S_DRAW);

  sprite_scan u_scan (
    .clk     (clk),
    .reset   (reset),
    .start   (w_scan_start),
    .advance (w_scan_adv),
    .size_m1 (c_size_m1),
    .dx      (w_dx),
    .dy      (w_dy),
    .last    (w_last)
  );

  // Current pixel: erase works on the old square, draw on the new one
  assign w_base_x  = (r_state == S_ERASE) ? r_old_x : r_new_x;
  assign w_base_y  = (r_state == S_ERASE) ? r_old_y : r_new_y;
  assign w_sum_x   = {1'b0, w_base_x} + {{(c_coord_w - 3){1'b0}}, w_dx};
  assign w_sum_y   = {1'b0, w_base_y} + {{(c_coord_w - 3){1'b0}}, w_dy};
  assign w_visible = on_screen(w_sum_x, c_screen_w) && on_screen(w_sum_y, c_screen_h);

  // Sequencer with registered pixel-write outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_new_x    <= '0;
      r_new_y    <= '0;
      r_old_x    <= '0;
      r_old_y    <= '0;
      r_have_old <= 1'b0;
      ready      <= 1'b1;
      plot       <= 1'b0;
      done       <= 1'b0;
      plot_x     <= '0;
      plot_y     <= '0;
      colour     <= BG_COLOUR;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          plot <= 1'b0;
          done <= 1'b0;
          if (w_accept) begin
            r_new_x <= X;
            r_new_y <= Y;
            ready   <= 1'b0;
`ifdef BALL_SKIP_STILL_EN
            if (r_have_old && (X == r_old_x) && (Y == r_old_y)) begin
              r_state <= S_DONE;
            end else if (r_have_old) begin
              r_state <= S_ERASE;
            end else begin
              r_state <= S_DRAW;
            end
`else
            if (r_have_old) begin
              r_state <= S_ERASE;
            end else begin
              r_state <= S_DRAW;
            end
`endif
          end
        end

        S_ERASE: begin
          plot_x <= w_sum_x[c_coord_w-1:0];
          plot_y <= w_sum_y[c_coord_w-1:0];
          colour <= BG_COLOUR;
          plot   <= w_visible;
          if (w_last) begin
            r_state <= S_DRAW;
          end
        end

        S_DRAW: begin
          plot_x <= w_sum_x[c_coord_w-1:0];
          plot_y <= w_sum_y[c_coord_w-1:0];
          colour <= BALL_COLOUR;
          plot   <= w_visible;
          if (w_last) begin
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          // First cycle here raises done (the last pixel write is still
          // being presented on entry); the second returns to IDLE
          plot <= 1'b0;
          if (!done) begin
            done       <= 1'b1;
            r_old_x    <= r_new_x;
            r_old_y    <= r_new_y;
            r_have_old <= 1'b1;
          end else begin
            done    <= 1'b0;
            ready   <= 1'b1;
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          ready   <= 1'b1;
          plot    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
